spatial_decoder: RTL and testbench

Inverse of the spatial encoding path. It takes a bundled spatial hypervector and one channel item hypervector, and unbinds them by XOR. It then measures the Hamming distance of the result to the positive and negative projection vectors. From these it recovers the channel's 2-bit feature code (2'd1 positive, 2'd2 negative, 2'd0 absent). Distances are computed serially, one chunk per cycle, so it sits beside the encoder for self-check and channel-recovery experiments.

---
 rtl/spatial_decoder_if.sv | 40 ++++
 rtl/spatial_decoder.sv | 192 +++++++++++++++++++
 tb/tb_spatial_decoder.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/spatial_decoder_if.sv
// Operand/result bundle for spatial_decoder.
// The master side supplies operands and consumes results; the slave side is the decoder.
// Margin_DO exists only when SPATIAL_DECODER_MARGIN_EN is defined.
interface spatial_decoder_if #(
    parameter int DIMENSION     = 2000,
    parameter int CHANNEL_WIDTH = 2
);
    localparam int DW = $clog2(DIMENSION + 1);

    logic                     ValidIn_SI;
    logic                     ReadyOut_SO;
    logic [0:DIMENSION-1]     SpatialHV_DI;
    logic [0:DIMENSION-1]     ItemHV_DI;
    logic [0:DIMENSION-1]     projM_posIN;
    logic [0:DIMENSION-1]     projM_negIN;
    logic                     ValidOut_SO;
    logic                     ReadyIn_SI;
    logic [CHANNEL_WIDTH-1:0] FeatureOut_DO;
    logic [DW-1:0]            DistPos_DO;
    logic [DW-1:0]            DistNeg_DO;
`ifdef SPATIAL_DECODER_MARGIN_EN
    logic [DW-1:0]            Margin_DO;
`endif

    modport master (
        output ValidIn_SI, SpatialHV_DI, ItemHV_DI, projM_posIN, projM_negIN, ReadyIn_SI,
        input  ReadyOut_SO, ValidOut_SO, FeatureOut_DO, DistPos_DO, DistNeg_DO
`ifdef SPATIAL_DECODER_MARGIN_EN
        , input Margin_DO
`endif
    );

    modport slave (
        input  ValidIn_SI, SpatialHV_DI, ItemHV_DI, projM_posIN, projM_negIN, ReadyIn_SI,
        output ReadyOut_SO, ValidOut_SO, FeatureOut_DO, DistPos_DO, DistNeg_DO
`ifdef SPATIAL_DECODER_MARGIN_EN
        , output Margin_DO
`endif
    );
endinterface

// File: rtl/spatial_decoder.sv
// spatial_decoder: unbinds a channel item from a bundled spatial hypervector and recovers
// the channel's 2-bit feature code from the Hamming distances to the positive/negative
// projection vectors. Distances are accumulated one CHUNK_WIDTH slice per cycle.
// Optional build macro: SPATIAL_DECODER_MARGIN_EN adds Margin_DO = |DistPos-DistNeg| and
// forces an absent code when that margin is below MARGIN_MIN.
module spatial_decoder #(
    parameter int DIMENSION     = 2000,
    parameter int CHUNK_WIDTH   = 100,
    parameter int CHANNEL_WIDTH = 2,
    parameter int ZERO_THRESH   = 900,
    parameter int MARGIN_MIN    = 50
) (
    input  logic             Clk_CI,
    input  logic             Reset_RBI,
    input  logic             Clear_SI,
    spatial_decoder_if.slave dec_if
);
    localparam int NUM_CHUNKS = DIMENSION / CHUNK_WIDTH;
    localparam int DW         = $clog2(DIMENSION + 1);
    localparam int PW         = $clog2(CHUNK_WIDTH + 1);
    localparam int CNT_W      = $clog2(NUM_CHUNKS + 1);

    if (((DIMENSION % CHUNK_WIDTH) != 0) || (NUM_CHUNKS < 1) || (MARGIN_MIN < 0)) begin : g_cfg_err
        $error("spatial_decoder: DIMENSION must be a positive multiple of CHUNK_WIDTH and MARGIN_MIN >= 0");
    end

    typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DONE} state_t;

    state_t                   state_q;
    logic [CNT_W-1:0]         cnt_q;
    logic [DW-1:0]            acc_pos_q, acc_neg_q;
    logic [DW-1:0]            acc_pos_d, acc_neg_d;
    logic [0:DIMENSION-1]     pos_res_q, neg_res_q;
    logic [0:DIMENSION-1]     unbound_d;
    logic                     valid_q;
    logic [CHANNEL_WIDTH-1:0] feat_q;
    logic [DW-1:0]            dist_pos_q, dist_neg_q;
`ifdef SPATIAL_DECODER_MARGIN_EN
    logic [DW-1:0]            margin_q;
`endif
    logic [PW-1:0]            pc_pos, pc_neg;
    logic                     ready;
    logic                     accept;
    logic                     chunks_done;
    logic                     shift_en;

    function automatic logic [PW-1:0] popcount(input logic [CHUNK_WIDTH-1:0] v);
        logic [PW-1:0] s;
        s = '0;
        for (int i = 0; i < CHUNK_WIDTH; i++) begin
            s = s + PW'(v[i]);
        end
        return s;
    endfunction

`ifdef SPATIAL_DECODER_MARGIN_EN
    function automatic logic [DW-1:0] absdiff(input logic [DW-1:0] a, input logic [DW-1:0] b);
        logic signed [DW:0] diff;
        diff = $signed({1'b0, a}) - $signed({1'b0, b});
        if (diff < 0) begin
            diff = -diff;
        end
        return diff[DW-1:0];
    endfunction
`endif

    function automatic logic [CHANNEL_WIDTH-1:0] decide(input logic [DW-1:0] dp, input logic [DW-1:0] dn);
        logic [CHANNEL_WIDTH-1:0] f;
        if ((dp > DW'(ZERO_THRESH)) && (dn > DW'(ZERO_THRESH))) begin
            f = '0;
        end else if (dp < dn) begin
            f = CHANNEL_WIDTH'(1);
        end else if (dn < dp) begin
            f = CHANNEL_WIDTH'(2);
        end else begin
            f = '0;
        end
`ifdef SPATIAL_DECODER_MARGIN_EN
        // A small margin means the item is equally (un)like both projections.
        if (absdiff(dp, dn) < DW'(MARGIN_MIN)) begin
            f = '0;
        end
`endif
        return f;
    endfunction

    // A finished result may be released and a new operand set taken in the same cycle.
    assign ready       = (state_q == S_IDLE) || ((state_q == S_DONE) && dec_if.ReadyIn_SI);
    assign accept      = dec_if.ValidIn_SI && ready && !Clear_SI;
    assign chunks_done = (cnt_q == CNT_W'(NUM_CHUNKS));
    assign shift_en    = (state_q == S_ACCUM) && !chunks_done && !Clear_SI;

    // Unbind the operands and popcount the leading chunk of each difference vector.
    always_comb begin
        unbound_d = dec_if.SpatialHV_DI ^ dec_if.ItemHV_DI;
        pc_pos    = popcount(pos_res_q[0:CHUNK_WIDTH-1]);
        pc_neg    = popcount(neg_res_q[0:CHUNK_WIDTH-1]);
        acc_pos_d = acc_pos_q + DW'(pc_pos);
        acc_neg_d = acc_neg_q + DW'(pc_neg);
    end

    // Difference vectors: captured on accept, then shifted so chunk k always sits at bit 0.
    always_ff @(posedge Clk_CI) begin
        if (accept) begin
            pos_res_q <= unbound_d ^ dec_if.projM_posIN;
            neg_res_q <= unbound_d ^ dec_if.projM_negIN;
        end else if (shift_en) begin
            pos_res_q <= pos_res_q << CHUNK_WIDTH;
            neg_res_q <= neg_res_q << CHUNK_WIDTH;
        end
    end

    // Control FSM: accumulate NUM_CHUNKS slices, then spend one more ACCUM cycle registering
    // the decision from the settled accumulators, so the compare never chains behind the adder.
    always_ff @(posedge Clk_CI or negedge Reset_RBI) begin
        if (!Reset_RBI) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            acc_pos_q  <= '0;
            acc_neg_q  <= '0;
            valid_q    <= 1'b0;
            feat_q     <= '0;
            dist_pos_q <= '0;
            dist_neg_q <= '0;
`ifdef SPATIAL_DECODER_MARGIN_EN
            margin_q   <= '0;
`endif
        end else if (Clear_SI) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            acc_pos_q  <= '0;
            acc_neg_q  <= '0;
            valid_q    <= 1'b0;
            feat_q     <= '0;
            dist_pos_q <= '0;
            dist_neg_q <= '0;
`ifdef SPATIAL_DECODER_MARGIN_EN
            margin_q   <= '0;
`endif
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        acc_pos_q <= '0;
                        acc_neg_q <= '0;
                        cnt_q     <= '0;
                        state_q   <= S_ACCUM;
                    end
                end
                S_ACCUM: begin
                    if (chunks_done) begin
                        valid_q    <= 1'b1;
                        feat_q     <= decide(acc_pos_q, acc_neg_q);
                        dist_pos_q <= acc_pos_q;
                        dist_neg_q <= acc_neg_q;
`ifdef SPATIAL_DECODER_MARGIN_EN
                        margin_q   <= absdiff(acc_pos_q, acc_neg_q);
`endif
                        state_q    <= S_DONE;
                    end else begin
                        acc_pos_q <= acc_pos_d;
                        acc_neg_q <= acc_neg_d;
                        cnt_q     <= cnt_q + CNT_W'(1);
                    end
                end
                S_DONE: begin
                    if (dec_if.ReadyIn_SI) begin
                        valid_q <= 1'b0;
                        if (accept) begin
                            acc_pos_q <= '0;
                            acc_neg_q <= '0;
                            cnt_q     <= '0;
                            state_q   <= S_ACCUM;
                        end else begin
                            state_q <= S_IDLE;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign dec_if.ReadyOut_SO   = ready;
    assign dec_if.ValidOut_SO   = valid_q;
    assign dec_if.FeatureOut_DO = feat_q;
    assign dec_if.DistPos_DO    = dist_pos_q;
    assign dec_if.DistNeg_DO    = dist_neg_q;
`ifdef SPATIAL_DECODER_MARGIN_EN
    assign dec_if.Margin_DO     = margin_q;
`endif
endmodule

// File: tb/tb_spatial_decoder.sv
// Self-checking bench for spatial_decoder: directed cases plus randomized operands
// compared with a distance/decision model computed from whole vectors.
module tb_spatial_decoder;
    localparam int D   = 2000;
    localparam int CW  = 100;
    localparam int CHW = 2;
    localparam int ZT  = 900;
    localparam int MM  = 50;
    localparam int LAT = D / CW + 1;

    typedef logic [0:D-1] hv_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    logic clr   = 1'b0;
    int   checks = 0;
    int   errors = 0;

    int        e_dp, e_dn, e_mg;
    logic [1:0] e_f;

    spatial_decoder_if #(.DIMENSION(D), .CHANNEL_WIDTH(CHW)) dif ();

    spatial_decoder #(
        .DIMENSION(D), .CHUNK_WIDTH(CW), .CHANNEL_WIDTH(CHW),
        .ZERO_THRESH(ZT), .MARGIN_MIN(MM)
    ) dut (
        .Clk_CI(clk), .Reset_RBI(rst_n), .Clear_SI(clr), .dec_if(dif)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic hv_t rand_hv();
        hv_t v;
        for (int j = 0; j < D; j++) v[j] = 1'($urandom & 1);
        return v;
    endfunction

    function automatic hv_t flip_bits(input hv_t v, input int k);
        for (int j = 0; j < k; j++) v[$urandom_range(0, D - 1)] ^= 1'b1;
        return v;
    endfunction

    // Reference: whole-vector Hamming distances and the decision rules.
    task automatic ref_model(input hv_t s, input hv_t i, input hv_t p, input hv_t n);
        hv_t u;
        u    = s ^ i;
        e_dp = $countones(u ^ p);
        e_dn = $countones(u ^ n);
        e_mg = (e_dp > e_dn) ? e_dp - e_dn : e_dn - e_dp;
        if (e_dp > ZT && e_dn > ZT) e_f = 2'd0;
        else if (e_dp < e_dn)       e_f = 2'd1;
        else if (e_dn < e_dp)       e_f = 2'd2;
        else                        e_f = 2'd0;
`ifdef SPATIAL_DECODER_MARGIN_EN
        if (e_mg < MM) e_f = 2'd0;
`endif
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input hv_t s, input hv_t i, input hv_t p, input hv_t n);
        dif.SpatialHV_DI = s;
        dif.ItemHV_DI    = i;
        dif.projM_posIN  = p;
        dif.projM_negIN  = n;
        dif.ValidIn_SI   = 1'b1;
        step();
        dif.ValidIn_SI   = 1'b0;
        dif.SpatialHV_DI = ~s;
        dif.ItemHV_DI    = rand_hv();
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        do begin
            step();
            lat++;
        end while (!dif.ValidOut_SO && lat < 100);
    endtask

    task automatic chk_result(input string tag);
        chk({tag, "_vld"},  64'(dif.ValidOut_SO),   64'd1);
        chk({tag, "_dpos"}, 64'(dif.DistPos_DO),    64'(e_dp));
        chk({tag, "_dneg"}, 64'(dif.DistNeg_DO),    64'(e_dn));
        chk({tag, "_feat"}, 64'(dif.FeatureOut_DO), 64'(e_f));
`ifdef SPATIAL_DECODER_MARGIN_EN
        chk({tag, "_marg"}, 64'(dif.Margin_DO),     64'(e_mg));
`endif
    endtask

    task automatic run_txn(input string tag, input hv_t s, input hv_t i, input hv_t p, input hv_t n);
        int lat;
        ref_model(s, i, p, n);
        send(s, i, p, n);
        wait_valid(lat);
        chk({tag, "_lat"}, 64'(lat), 64'(LAT));
        chk_result(tag);
    endtask

    task automatic chk_zeroed(input string tag);
        chk({tag, "_vld"},  64'(dif.ValidOut_SO),   64'd0);
        chk({tag, "_rdy"},  64'(dif.ReadyOut_SO),   64'd1);
        chk({tag, "_dpos"}, 64'(dif.DistPos_DO),    64'd0);
        chk({tag, "_dneg"}, 64'(dif.DistNeg_DO),    64'd0);
        chk({tag, "_feat"}, 64'(dif.FeatureOut_DO), 64'd0);
`ifdef SPATIAL_DECODER_MARGIN_EN
        chk({tag, "_marg"}, 64'(dif.Margin_DO),     64'd0);
`endif
    endtask

    initial begin
        hv_t item, pos, neg, alt, mask, s, base;
        int  sel, k;

        dif.ValidIn_SI   = 1'b0;
        dif.ReadyIn_SI   = 1'b1;
        dif.SpatialHV_DI = '0;
        dif.ItemHV_DI    = '0;
        dif.projM_posIN  = '0;
        dif.projM_negIN  = '0;
        for (int j = 0; j < D; j++) begin
            alt[j]  = (j % 2 == 0);
            mask[j] = (j % 2 == 1);
        end

        // Reset state, observed before any clock edge
        #2 rst_n = 1'b0;
        #1;
        chk_zeroed("rst");
        #20 rst_n = 1'b1;
        step();

        // 1: spatial built from the positive projection
        item = rand_hv();
        pos  = rand_hv();
        neg  = pos ^ mask;
        run_txn("t1", item ^ pos, item, pos, neg);
        chk("t1_dpos_c", 64'(dif.DistPos_DO),    64'd0);
        chk("t1_dneg_c", 64'(dif.DistNeg_DO),    64'd1000);
        chk("t1_feat_c", 64'(dif.FeatureOut_DO), 64'd1);
`ifdef SPATIAL_DECODER_MARGIN_EN
        chk("t1_marg_c", 64'(dif.Margin_DO),     64'd1000);
`endif

        // 2: spatial built from the negative projection
        run_txn("t2", item ^ neg, item, pos, neg);
        chk("t2_dpos_c", 64'(dif.DistPos_DO),    64'd1000);
        chk("t2_dneg_c", 64'(dif.DistNeg_DO),    64'd0);
        chk("t2_feat_c", 64'(dif.FeatureOut_DO), 64'd2);

        // 3: both distances above the absent threshold
        run_txn("t3", '0, '0, '1, alt);
        chk("t3_dpos_c", 64'(dif.DistPos_DO),    64'd2000);
        chk("t3_dneg_c", 64'(dif.DistNeg_DO),    64'd1000);
        chk("t3_feat_c", 64'(dif.FeatureOut_DO), 64'd0);

        // 4: identical projections give a tie
        pos = rand_hv();
        run_txn("t4", item ^ pos, item, pos, pos);
        chk("t4_dpos_c", 64'(dif.DistPos_DO),    64'd0);
        chk("t4_feat_c", 64'(dif.FeatureOut_DO), 64'd0);

        // 5: backpressure in DONE, then back-to-back accept on release
        step();
        dif.ReadyIn_SI = 1'b0;
        item = rand_hv();
        pos  = rand_hv();
        neg  = rand_hv();
        run_txn("t5a", item ^ flip_bits(pos, 100), item, pos, neg);
        for (int c = 0; c < 5; c++) begin
            step();
            chk_result("t5_hold");
            chk("t5_hold_rdy", 64'(dif.ReadyOut_SO), 64'd0);
        end
        dif.ReadyIn_SI = 1'b1;
        #1;
        chk("t5_rdy_release", 64'(dif.ReadyOut_SO), 64'd1);
        run_txn("t5b", item ^ flip_bits(neg, 200), item, pos, neg);

        // 6a: asynchronous reset in the middle of accumulation
        run_txn("t6a", '0, '0, '1, alt);
        send(item ^ pos, item, pos, neg);
        repeat (10) step();
        chk("t6a_rdy_accum", 64'(dif.ReadyOut_SO), 64'd0);
        chk("t6a_vld_accum", 64'(dif.ValidOut_SO), 64'd0);
        rst_n = 1'b0;
        #1;
        chk_zeroed("t6a_rst");
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // 6b: synchronous clear in the middle of accumulation
        run_txn("t6b", '0, '0, '1, alt);
        send(item ^ pos, item, pos, neg);
        repeat (10) step();
        clr = 1'b1;
        step();
        clr = 1'b0;
        chk_zeroed("t6b_clr");
        run_txn("t6c", item ^ flip_bits(pos, 300), item, pos, neg);

        // Randomized operands against the reference model
        for (int t = 0; t < 8; t++) begin
            item = rand_hv();
            pos  = rand_hv();
            neg  = rand_hv();
            sel  = int'($urandom_range(0, 2));
            k    = int'($urandom_range(0, 500));
            base = (sel == 0) ? pos : (sel == 1) ? neg : rand_hv();
            s    = item ^ flip_bits(base, k);
            run_txn("rnd", s, item, pos, neg);
        end

        step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
